// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer on the M-stage data bus: CTRL/PRESET/COUNT registers, expiry irq.
// Optional prescaled tick enabled by defining TIMER_PRESCALE_EN.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
`ifdef TIMER_PRESCALE_EN
  , parameter int unsigned PRESCALE = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_PRESET = 2'd1;
  localparam logic [1:0] SEL_COUNT  = 2'd2;

  localparam logic [1:0] MODE_RELOAD = 2'd1;

  logic [1:0]        state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              irq_flag_q, irq_flag_d;
  logic              irq_q, irq_d;

  logic       hit;
  logic [1:0] sel;
  logic       wr_ctrl, wr_preset;
  logic       tick;
  logic       unused_addr;

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel         = addr[3:2];
  assign wr_ctrl     = we & hit & (sel == SEL_CTRL);
  assign wr_preset   = we & hit & (sel == SEL_PRESET);
  assign unused_addr = ^addr[1:0];

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PSC_W-1:0] psc_q, psc_d;

  assign tick = (psc_q == PSC_W'(PRESCALE - 1));

  // Prescale counter: cleared on LOAD, advances every enabled CNT cycle, wraps on a tick.
  always_comb begin
    psc_d = psc_q;
    if (state_q == S_LOAD) begin
      psc_d = '0;
    end else if ((state_q == S_CNT) && ctrl_q[0]) begin
      psc_d = tick ? '0 : psc_q + PSC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) psc_q <= '0;
    else       psc_q <= psc_d;
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state: bus writes clear the sticky flag first, FSM actions may override,
  // and a CPU CTRL write wins over the one-shot auto-clear of EN.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    if (wr_ctrl || wr_preset) irq_flag_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (count_q <= DATA_W'(1)) begin
            count_d    = '0;
            irq_flag_d = 1'b1;
            state_d    = S_INT;
          end else begin
            count_d = count_q - DATA_W'(1);
          end
        end
      end
      S_INT: begin
        if (ctrl_q[2:1] == MODE_RELOAD) begin
          irq_flag_d = 1'b0;
          state_d    = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_ctrl)   ctrl_d   = wdata[CTRL_W-1:0];
    if (wr_preset) preset_d = wdata;

    irq_d = irq_flag_d & ctrl_d[3];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

  // Combinational read port so lw completes in the same M cycle as a DM read.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        SEL_CTRL:   rdata = DATA_W'(ctrl_q);
        SEL_PRESET: rdata = preset_q;
        SEL_COUNT:  rdata = count_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: register-map vector table, timing sequences,
// and randomized bus traffic checked against a cycle-level behavioural model.
module tb_mmio_timer;

`ifdef TIMER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  mmio_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Behavioural model: timer phases, counts and the sticky expiry flag.
  localparam int M_STOPPED = 0;
  localparam int M_ARMING  = 1;
  localparam int M_RUNNING = 2;
  localparam int M_EXPIRED = 3;

  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  int          m_ph;
  int          m_psc;
  logic        m_flag;
  logic        m_irq;

  task automatic model_reset();
    m_ctrl = '0; m_preset = '0; m_count = '0;
    m_ph = M_STOPPED; m_psc = 0; m_flag = 1'b0; m_irq = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:4] != 28'h00007F0) return 32'h0;
    case (a[3:2])
      2'd0:    return {28'h0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        hit, wc, wp, nf;
    logic [3:0]  nc;
    logic [31:0] np, ncnt;
    int          nph, npsc;
    hit  = (a[31:4] == 28'h00007F0);
    wc   = w && hit && (a[3:2] == 2'd0);
    wp   = w && hit && (a[3:2] == 2'd1);
    nc = m_ctrl; np = m_preset; ncnt = m_count; nph = m_ph; npsc = m_psc; nf = m_flag;
    if (wc || wp) nf = 1'b0;
    case (m_ph)
      M_STOPPED: if (m_ctrl[0]) nph = M_ARMING;
      M_ARMING: begin
        ncnt = m_preset; npsc = 0; nph = M_RUNNING;
      end
      M_RUNNING: begin
        if (!m_ctrl[0]) nph = M_STOPPED;
        else begin
          npsc = m_psc + 1;
          if (npsc == PS) begin
            npsc = 0;
            if (m_count <= 1) begin
              ncnt = 0; nf = 1'b1; nph = M_EXPIRED;
            end else ncnt = m_count - 1;
          end
        end
      end
      M_EXPIRED: begin
        if (m_ctrl[2:1] == 2'd1) begin
          nph = M_ARMING; nf = 1'b0;
        end else begin
          nc[0] = 1'b0; nph = M_STOPPED;
        end
      end
      default: ;
    endcase
    if (wc) nc = d[3:0];
    if (wp) np = d;
    m_ctrl = nc; m_preset = np; m_count = ncnt; m_ph = nph; m_psc = npsc; m_flag = nf;
    m_irq = nf & nc[3];
  endtask

  // One bus cycle: drive in the low phase, sample outputs, check against the model,
  // then advance the model for the coming rising edge.
  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic iq);
    @(negedge clk);
    we = w; addr = a; wdata = d;
    #1;
    rd = rdata; iq = irq;
    check("model_rdata", rdata, model_read(a));
    check("model_irq", {31'h0, irq}, {31'h0, m_irq});
    model_step(w, a, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    logic        ei;
  } vec_t;

  vec_t tv[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        iq;
    logic        done;
    int          first, per, expire;
    logic [31:0] exp_hold;

    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    model_reset();

    tv.push_back('{1'b0, 32'h7F00, 32'h0,        32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h7F04, 32'h0,        32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h7F08, 32'h0,        32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h7F0C, 32'h0,        32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h7F10, 32'h0,        32'h0, 1'b0});
    tv.push_back('{1'b1, 32'h7F04, 32'h5,        32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h7F04, 32'h0,        32'h5, 1'b0});
    tv.push_back('{1'b0, 32'h7F07, 32'h0,        32'h5, 1'b0});
    tv.push_back('{1'b1, 32'h7F0C, 32'hFFFFFFFF, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h7F0C, 32'h0,        32'h0, 1'b0});
    tv.push_back('{1'b1, 32'h7F08, 32'h123,      32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h7F08, 32'h0,        32'h0, 1'b0});
    tv.push_back('{1'b1, 32'h7F14, 32'hAAAA,     32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h7F04, 32'h0,        32'h5, 1'b0});
    tv.push_back('{1'b1, 32'h7F00, 32'hFFFFFFF6, 32'h0, 1'b0});
    tv.push_back('{1'b0, 32'h7F00, 32'h0,        32'h6, 1'b0});
    tv.push_back('{1'b0, 32'h7F10, 32'h0,        32'h0, 1'b0});
    tv.push_back('{1'b1, 32'h7F00, 32'h0,        32'h6, 1'b0});
    tv.push_back('{1'b0, 32'h7F00, 32'h0,        32'h0, 1'b0});

    do_reset();
    foreach (tv[i]) begin
      cycle(tv[i].w, tv[i].a, tv[i].d, rd, iq);
      check($sformatf("vec%0d_rdata", i), rd, tv[i].er);
      check($sformatf("vec%0d_irq", i), {31'h0, iq}, {31'h0, tv[i].ei});
    end

    // One-shot, PRESET=5, EN|IM.
    do_reset();
    cycle(1'b1, 32'h7F04, 32'd5, rd, iq);
    cycle(1'b1, 32'h7F00, 32'h9, rd, iq);
    for (int k = -2; k <= 5 * PS; k++) begin
      cycle(1'b0, 32'h7F08, 32'h0, rd, iq);
      if (k >= 0) begin
        check("oneshot_count", rd, (k < 5 * PS) ? 32'(5 - k / PS) : 32'h0);
        check("oneshot_irq", {31'h0, iq}, (k == 5 * PS) ? 32'h1 : 32'h0);
      end
    end
    for (int j = 0; j < 20; j++) begin
      cycle(1'b0, 32'h7F00, 32'h0, rd, iq);
      check("oneshot_irq_hold", {31'h0, iq}, 32'h1);
      check("oneshot_ctrl", rd, 32'h8);
    end
    cycle(1'b1, 32'h7F00, 32'h8, rd, iq);
    cycle(1'b0, 32'h7F00, 32'h0, rd, iq);
    check("oneshot_irq_clr", {31'h0, iq}, 32'h0);

    // Auto-reload, PRESET=3: one-cycle pulses with period LOAD + 3 ticks + INT.
    do_reset();
    cycle(1'b1, 32'h7F04, 32'd3, rd, iq);
    cycle(1'b1, 32'h7F00, 32'hB, rd, iq);
    first = 2 + 3 * PS;
    per   = 3 * PS + 2;
    for (int e = 0; e <= first + 2 * per + 1; e++) begin
      cycle(1'b0, 32'h7F08, 32'h0, rd, iq);
      check("reload_irq", {31'h0, iq},
            (e >= first && ((e - first) % per) == 0) ? 32'h1 : 32'h0);
      if (e == first)     check("reload_count_zero", rd, 32'h0);
      if (e == first + 2) check("reload_count_reload", rd, 32'h3);
    end

    // Disable mid-count: count freezes, re-enable reloads from PRESET.
    do_reset();
    cycle(1'b1, 32'h7F04, 32'd10, rd, iq);
    cycle(1'b1, 32'h7F00, 32'h9, rd, iq);
    done = 1'b0;
    for (int j = 0; j < 80 && !done; j++) begin
      if (m_ph == M_RUNNING && m_count == 32'd7) begin
        cycle(1'b1, 32'h7F00, 32'h8, rd, iq);
        done = 1'b1;
      end else begin
        cycle(1'b0, 32'h7F08, 32'h0, rd, iq);
      end
    end
    check("disable_reached", {31'h0, done}, 32'h1);
    exp_hold = (PS == 1) ? 32'd6 : 32'd7;
    cycle(1'b0, 32'h7F08, 32'h0, rd, iq);
    for (int j = 0; j < 6; j++) begin
      cycle(1'b0, 32'h7F08, 32'h0, rd, iq);
      check("disable_count_hold", rd, exp_hold);
      check("disable_no_irq", {31'h0, iq}, 32'h0);
    end
    cycle(1'b1, 32'h7F00, 32'h9, rd, iq);
    cycle(1'b0, 32'h7F08, 32'h0, rd, iq);
    cycle(1'b0, 32'h7F08, 32'h0, rd, iq);
    cycle(1'b0, 32'h7F08, 32'h0, rd, iq);
    check("reenable_reload", rd, 32'd10);

    // PRESET=0 with IM=0: expiry sets the flag internally but irq stays low.
    do_reset();
    cycle(1'b1, 32'h7F04, 32'd0, rd, iq);
    cycle(1'b1, 32'h7F00, 32'h1, rd, iq);
    for (int e = 0; e < 8; e++) begin
      cycle(1'b0, 32'h7F08, 32'h0, rd, iq);
      check("masked_irq", {31'h0, iq}, 32'h0);
      if (e == 2 + PS) check("masked_count", rd, 32'h0);
    end
    cycle(1'b1, 32'h7F00, 32'h8, rd, iq);
    for (int e = 0; e < 3; e++) begin
      cycle(1'b0, 32'h7F00, 32'h0, rd, iq);
      check("masked_unmask_irq", {31'h0, iq}, 32'h0);
    end

    // Asynchronous reset while the one-shot irq is held.
    do_reset();
    cycle(1'b1, 32'h7F04, 32'd2, rd, iq);
    cycle(1'b1, 32'h7F00, 32'h9, rd, iq);
    expire = 2 + 2 * PS;
    for (int e = 0; e <= expire + 1; e++) begin
      cycle(1'b0, 32'h7F08, 32'h0, rd, iq);
      if (e == expire) check("areset_expire_irq", {31'h0, iq}, 32'h1);
    end
    @(negedge clk);
    we = 1'b0; addr = 32'h7F08;
    #2;
    check("areset_irq_before", {31'h0, irq}, 32'h1);
    reset = 1'b1;
    #1;
    check("areset_count", rdata, 32'h0);
    check("areset_irq", {31'h0, irq}, 32'h0);
    addr = 32'h7F00;
    #1;
    check("areset_ctrl", rdata, 32'h0);

    // Randomized bus traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a, d;
      logic        w;
      case ($urandom_range(0, 5))
        0:       a = 32'h7F00;
        1:       a = 32'h7F04;
        2:       a = 32'h7F08;
        3:       a = 32'h7F0C;
        4:       a = 32'h7F10;
        default: a = 32'h7F08;
      endcase
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) a = $urandom;
      w = ($urandom_range(0, 9) == 0);
      d = (a[3:2] == 2'd1) ? 32'($urandom_range(0, 9)) : $urandom;
      cycle(w, a, d, rd, iq);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
